bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter for the shared memory interconnect. Grants bus ownership to one of
//  NREQ requesters (icache, dcache, DMA, ...) and holds the grant until the owner signals done.
//  Drives the grant_in / bus_busy_in inputs of each cache controller. Sits between the
//  requesters' mem_req / mem_done outputs and the interconnect.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  IDW      2   width of owner_id; NREQ <= 2**IDW
//  TIMEOUT  64  max ownership cycles before forced release (only with BUS_ARB_TIMEOUT_EN)
//  CNTW     8   watchdog counter width; TIMEOUT < 2**CNTW
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-low reset
//  req        in   NREQ  per-requester bus request (level; held until granted)
//  done       in   NREQ  per-requester transfer-complete pulse
//  grant      out  NREQ  one-hot ownership grant, registered
//  bus_busy   out  1     bus owned or in turnaround, registered
//  owner_id   out  IDW   index of current owner; valid while grant != 0
//  timeout    out  1     sticky watchdog flag (tied 0 without BUS_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, grant=0, bus_busy=0, owner_id=0, rr_ptr=0, timeout=0.
//  States:
//   IDLE  - if |req: pick first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//           Next cycle: state=OWN, grant=onehot(i), owner_id=i, bus_busy=1. Else stay.
//   OWN   - grant held. Release when done[owner_id]=1 OR req[owner_id]=0 (abort).
//           Next cycle: state=TURN, grant=0, bus_busy=1, rr_ptr=(owner_id+1) mod NREQ.
//   TURN  - one dead cycle for bus turnaround; bus_busy=0 at the following edge, state=IDLE.
//  Latency: req rising in IDLE at cycle 0 -> grant=1 at cycle 1.
//   done at cycle k -> grant=0 at k+1 (TURN) -> IDLE at k+2 -> next grant at k+3.
//  Rules / boundaries:
//   - grant is always one-hot or zero; never changes while in OWN.
//   - done[] from non-owners, and done in IDLE/TURN, are ignored.
//   - Simultaneous requests: the lowest index at or after rr_ptr wins; wrap from NREQ-1 to 0.
//   - The requester just released has the lowest priority on the next arbitration (fairness).
//   - req asserted during OWN/TURN is held pending; it is not lost.
//   - done and req drop in the same cycle: a single release; no double rr_ptr advance.
//   - reset asserted mid-OWN: grant drops immediately (async); no done is required.
//   - rr_ptr arithmetic is mod NREQ; when NREQ is not a power of 2, an increment past
//     NREQ-1 wraps to 0.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//   - A CNTW-bit counter clears on entry to OWN and increments each OWN cycle.
//   - When the counter reaches TIMEOUT-1 without a release, the arbiter forces the
//     OWN->TURN transition exactly like a done, and sets timeout=1 (sticky until reset).
//  BUS_ARB_TIMEOUT_EN undefined:
//   - No counter is built; timeout is tied to 0; ownership is unbounded.
// TESTING
//  1 reset=0 with req=4'b1111 -> grant=0, bus_busy=0, timeout=0; release reset -> grant=0001
//    one cycle later.
//  2 req=4'b1111, each owner pulses done 3 cycles after its grant -> grant sequence
//    0001,0010,0100,1000,0001; gap of 2 cycles with grant=0 between owners.
//  3 owner 2 done while req=4'b0101 -> next grant=0001? no: rr_ptr=3, scan 3,0 ->
//    grant=0001 at done+3.
//  4 grant=0010, done=4'b0001 (non-owner) -> grant stays 0010; req[1] dropped ->
//    grant=0 next cycle.
//  5 reset pulsed low mid-OWN -> grant=0 and bus_busy=0 within the same cycle; owner_id=0.
//  6 (BUS_ARB_TIMEOUT_EN, TIMEOUT=8) owner never done -> grant drops after 8 OWN cycles,
//    timeout=1 and stays 1 through later grants.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter; grant held until done/abort, one-cycle turnaround.
// Ports: clk, reset (async active-low), req[NREQ] level requests, done[NREQ] completion pulses,
//        grant[NREQ] one-hot registered grant, bus_busy (owned or turnaround), owner_id, timeout (sticky).
// Optional watchdog forced release enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic            bus_busy,
  output logic [IDW-1:0]  owner_id,
  output logic            timeout
);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t state, state_nx;
  logic [NREQ-1:0] grant_nx;
  logic busy_nx, found, release_own, tmo_hit;
  logic [IDW-1:0] owner_nx, rr_ptr, rr_nx, pick, idx;
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
`ifdef BUS_ARB_TIMEOUT_EN
  logic [CNTW-1:0] cnt;
  assign tmo_hit = state == OWN && cnt == CNTW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= state == OWN ? cnt + 1'b1 : '0;
      if (tmo_hit && !done[owner_id] && req[owner_id]) timeout <= 1'b1;
    end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    busy_nx = bus_busy;
    owner_nx = owner_id;
    rr_nx = rr_ptr;
    release_own = done[owner_id] || !req[owner_id] || tmo_hit;
    unique case (state)
      IDLE: if (found) begin
        state_nx = OWN;
        grant_nx = NREQ'(1) << pick;
        owner_nx = pick;
        busy_nx = 1'b1;
      end
      OWN: if (release_own) begin
        state_nx = TURN;
        grant_nx = '0;
        rr_nx = owner_id == IDW'(NREQ - 1) ? '0 : owner_id + 1'b1;
      end
      TURN: begin
        state_nx = IDLE;
        busy_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      bus_busy <= 1'b0;
      owner_id <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      bus_busy <= busy_nx;
      owner_id <= owner_nx;
      rr_ptr <= rr_nx;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a cycle model and literal checks for bus_arbiter.
module tb_bus_arbiter;
  localparam int NREQ = 4;
  localparam int TMO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic bus_busy, timeout;
  logic [1:0] owner_id;
  int errors = 0, checks = 0;
  int m_phase = 0, m_owner = 0, m_rr = 0, m_cnt = 0, w = 0;
  bit m_to = 1'b0, rel = 1'b0, tmo = 1'b0;
  logic [3:0] g;
  int gap, n;
  logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  bus_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(TMO), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .bus_busy(bus_busy), .owner_id(owner_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_req(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (((r >> ((p + k) % NREQ)) & 4'b1) != 4'b0) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_to = 1'b0;
    end else if (m_phase == 0) begin
      w = pick_req(req, m_rr);
      if (w >= 0) begin m_phase = 1; m_owner = w; m_cnt = 0; end
    end else if (m_phase == 1) begin
      rel = ((done >> m_owner) & 4'b1) != 4'b0 || ((req >> m_owner) & 4'b1) == 4'b0;
      tmo = TMO_EN && m_cnt == TMO - 1;
      if (rel || tmo) begin
        if (!rel) m_to = 1'b1;
        m_phase = 2;
        m_rr = (m_owner + 1) % NREQ;
      end else m_cnt++;
    end else m_phase = 0;
  end

  always @(negedge clk) begin
    check("model_grant", grant, m_phase == 1 ? 4'b0001 << m_owner : 4'b0000);
    check("model_busy", bus_busy, m_phase != 0);
    check("model_timeout", timeout, m_to);
    check("onehot0", $onehot0(grant), 1);
    if (m_phase == 1) check("model_owner_id", owner_id, m_owner);
  end

  task automatic wait_grant(output logic [3:0] gr, output int gp);
    gp = 0;
    while (grant == 4'b0000 && gp < 20) begin
      @(negedge clk);
      gp++;
    end
    if (grant == 4'b0000) begin
      errors++;
      checks++;
      $display("FAIL wait_grant: grant still 0 after %0d cycles, required nonzero", gp);
    end
    gr = grant;
  endtask

  initial begin
    req = 4'b1111;
    repeat (2) @(negedge clk);
    check("t1_reset_grant", grant, 4'b0000);
    check("t1_reset_busy", bus_busy, 0);
    check("t1_reset_timeout", timeout, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t1_first_grant", grant, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, gap);
      check("t2_grant_seq", g, seq[i]);
      if (i > 0) check("t2_gap", gap, 2);
      repeat (2) @(negedge clk);
      done = g;
      @(negedge clk);
      done = 4'b0000;
    end
    req = 4'b0100;
    wait_grant(g, gap);
    check("t3_owner2", g, 4'b0100);
    req = 4'b0101;
    repeat (2) @(negedge clk);
    done = 4'b0100;
    @(negedge clk);
    done = 4'b0000;
    wait_grant(g, gap);
    check("t3_wrap_grant", g, 4'b0001);
    check("t3_gap", gap, 2);
    req = 4'b0010;
    done = 4'b0001;
    @(negedge clk);
    done = 4'b0000;
    wait_grant(g, gap);
    check("t4_grant", g, 4'b0010);
    done = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_nonowner_done", grant, 4'b0010);
    end
    done = 4'b0000;
    req = 4'b0000;
    @(negedge clk);
    check("t4_abort_grant", grant, 4'b0000);
    check("t4_abort_busy", bus_busy, 1);
    req = 4'b1000;
    wait_grant(g, gap);
    check("t5_grant", g, 4'b1000);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_async_grant", grant, 4'b0000);
    check("t5_async_busy", bus_busy, 0);
    check("t5_async_owner", owner_id, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_grant(g, gap);
    check("t5_regrant", g, 4'b1000);
    done = 4'b1000;
    req = 4'b0000;
    @(negedge clk);
    done = 4'b0000;
    req = 4'b0011;
    wait_grant(g, gap);
    check("same_cycle_drop_grant", g, 4'b0001);
    check("same_cycle_drop_gap", gap, 2);
    n = 1;
    while (grant == 4'b0001 && n < 20) begin
      @(negedge clk);
      if (grant == 4'b0001) n++;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    check("t6_own_cycles", n, 8);
    check("t6_timeout_set", timeout, 1);
    wait_grant(g, gap);
    check("t6_next_grant", g, 4'b0010);
    check("t6_timeout_sticky", timeout, 1);
`else
    check("t6_unbounded_own", n, 20);
    check("t6_timeout_tied", timeout, 0);
    req = 4'b0000;
    @(negedge clk);
    check("t6_release_grant", grant, 4'b0000);
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
